// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared encodings and defaults for the multi-channel PWM generator
package pwm_pkg;

   localparam int DEFAULT_WIDTH = 12;

   typedef enum logic {
      MODE_EDGE   = 1'b0,
      MODE_CENTER = 1'b1
   } pwm_mode_e;

   typedef enum logic {
      PHASE_UP   = 1'b0,
      PHASE_DOWN = 1'b1
   } pwm_phase_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } commit_state_e;

endpackage

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - shared up / up-down period counter with boundary and start flags
module pwm_counter
   import pwm_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_period,
   input  pwm_mode_e        i_mode,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_boundary,
   output logic             o_start
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_next;
   pwm_phase_e       r_phase;
   pwm_phase_e       w_phase_next;
   logic             w_zero_period;
   logic             w_top;
   logic             w_bottom;

   assign w_zero_period = (i_period == '0);
   assign w_top         = (r_cnt == i_period - WIDTH'(1));
   assign w_bottom      = (r_cnt == '0);
   assign o_cnt         = r_cnt;
   assign o_start       = w_bottom && (r_phase == PHASE_UP);
   // A zero period is a one-cycle period: every cycle is both first and last.
   assign o_boundary    = w_zero_period ||
                          ((i_mode == MODE_EDGE) ? w_top : (w_bottom && (r_phase == PHASE_DOWN)));

   // Counter and phase registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_phase <= PHASE_UP;
      end else begin
         r_cnt   <= w_cnt_next;
         r_phase <= w_phase_next;
      end
   end

   // Next count: wrap in edge mode; in center mode the top and bottom values repeat once on turnaround
   always_comb begin
      w_cnt_next   = '0;
      w_phase_next = PHASE_UP;
      if (i_enable && !w_zero_period) begin
         if (i_mode == MODE_EDGE) begin
            if (!w_top) w_cnt_next = r_cnt + WIDTH'(1);
         end else if (r_phase == PHASE_UP) begin
            if (w_top) begin
               w_cnt_next   = r_cnt;
               w_phase_next = PHASE_DOWN;
            end else begin
               w_cnt_next = r_cnt + WIDTH'(1);
            end
         end else if (!w_bottom) begin
            w_cnt_next   = r_cnt - WIDTH'(1);
            w_phase_next = PHASE_DOWN;
         end
      end
   end

endmodule

// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-channel PWM with double-buffered duty, period and mode
module pwm_multi_gen
   import pwm_pkg::*;
#(
   parameter int WIDTH          = DEFAULT_WIDTH,
   parameter int CHANNELS       = 4,
   parameter int DEFAULT_PERIOD = 4095
) (
   input  logic                                           i_clk,
   input  logic                                           i_rst,
   input  logic                                           i_enable,
   input  logic                                           i_cfg_valid,
   output logic                                           o_cfg_ready,
   input  logic [$clog2((CHANNELS > 1) ? CHANNELS : 2)-1:0] i_cfg_chan,
   input  logic [WIDTH-1:0]                               i_cfg_duty,
   input  logic [WIDTH-1:0]                               i_cfg_period,
   input  logic                                           i_cfg_center,
   input  logic                                           i_update,
   output logic [CHANNELS-1:0]                            o_pwm,
   output logic                                           o_period_start
);

   localparam int CW = $clog2((CHANNELS > 1) ? CHANNELS : 2);

   commit_state_e    r_state;
   commit_state_e    w_state_next;
   logic             r_cfg_ready;
   logic [WIDTH-1:0] r_shadow_period;
   logic [WIDTH-1:0] r_active_period;
   pwm_mode_e        r_shadow_mode;
   pwm_mode_e        r_active_mode;
   logic             r_period_start;
   logic [WIDTH-1:0] w_cnt;
   logic             w_boundary;
   logic             w_start;
   logic             w_write;
   logic             w_arm;
   logic             w_commit;

   assign w_write        = i_cfg_valid && r_cfg_ready;
   assign w_arm          = i_update && (r_state == ST_IDLE);
   // While disabled there is no period to wait for, so an armed commit goes through at once.
   assign w_commit       = (r_state == ST_ARMED) && (w_boundary || !i_enable);
   assign o_cfg_ready    = r_cfg_ready;
   assign o_period_start = r_period_start;

   pwm_counter #(.WIDTH(WIDTH)) u_counter (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_enable   (i_enable),
      .i_period   (r_active_period),
      .i_mode     (r_active_mode),
      .o_cnt      (w_cnt),
      .o_boundary (w_boundary),
      .o_start    (w_start)
   );

   // Commit state register; cfg_ready is kept as its own flop mirroring the idle state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_cfg_ready <= 1'b1;
      end else begin
         r_state     <= w_state_next;
         r_cfg_ready <= (w_state_next == ST_IDLE);
      end
   end

   // Commit next-state: arm on update, disarm when the commit executes
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_update) w_state_next = ST_ARMED;
         ST_ARMED: if (w_commit) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Shadow and active period/mode, plus the registered period start pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shadow_period <= WIDTH'(DEFAULT_PERIOD);
         r_active_period <= WIDTH'(DEFAULT_PERIOD);
         r_shadow_mode   <= MODE_EDGE;
         r_active_mode   <= MODE_EDGE;
         r_period_start  <= 1'b0;
      end else begin
         if (w_arm) begin
            r_shadow_period <= i_cfg_period;
            r_shadow_mode   <= pwm_mode_e'(i_cfg_center);
         end
         if (w_commit) begin
            r_active_period <= r_shadow_period;
            r_active_mode   <= r_shadow_mode;
         end
         r_period_start <= i_enable && w_start;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic [WIDTH-1:0] r_shadow_duty;
      logic [WIDTH-1:0] r_active_duty;
      logic             r_pwm;
      logic             w_hit;
      logic [WIDTH:0]   w_sum;

      assign w_sum    = {1'b0, w_cnt} + {1'b0, r_active_duty};
      assign o_pwm[g] = r_pwm;

      // Edge mode is high at the bottom of the count, center mode straddles the top (cnt >= P - duty)
      always_comb begin
         w_hit = 1'b0;
         if (r_active_mode == MODE_EDGE) begin
            w_hit = (w_cnt < r_active_duty);
         end else begin
            w_hit = (r_active_duty != '0) && (w_sum >= {1'b0, r_active_period});
         end
      end

      // Per-channel shadow/active duty and registered output; out-of-range channels match nothing
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_shadow_duty <= '0;
            r_active_duty <= '0;
            r_pwm         <= 1'b0;
         end else begin
            if (w_write && (i_cfg_chan == CW'(g))) r_shadow_duty <= i_cfg_duty;
            if (w_commit) r_active_duty <= r_shadow_duty;
            r_pwm <= i_enable && w_hit;
         end
      end
   end

endmodule
